mem_arbiter: RTL

Two-port arbiter sharing the single-port instruction/data distributed RAM between the multi-cycle CPU (port 0) and the debug/program loader (port 1). It sits between both requesters and the memory and serialises their accesses with a fixed-latency req/ack handshake. Arbitration is round-robin, and reset gives the CPU first priority.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_pick2.sv | 50 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared constants for the two-port memory arbiter.
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - Port identifiers (CPU = port 0, debug/program loader = port 1)
//   - Small helper that turns a port id into a one-hot request mask
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // One-hot mask bit for a port id: bit 0 = CPU, bit 1 = debug.
  function automatic logic [1:0] port_onehot(input logic id);
    port_onehot = (id == PORT_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin pick.
//   Ports:
//     req0, req1   raw requests from port 0 / port 1
//     last         port served most recently; the other port wins a tie
//     mask         per-port request mask (bit n suppresses reqn)
//     lock         (MEM_ARB_LOCK_EN only) port 1 wins whenever it requests
//     grant_valid  some unmasked request is present
//     grant_id     port chosen when grant_valid is high
//   Optional feature macro: MEM_ARB_LOCK_EN.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  input  logic [1:0] mask,
`ifdef MEM_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       grant_valid,
  output logic       grant_id
);

  logic eff0;
  logic eff1;

  // A masked port drops out of the decision entirely, so a masked port-1
  // request can never hold off port 0, even with the lock asserted.
  assign eff0 = req0 & ~mask[0];
  assign eff1 = req1 & ~mask[1];

  always_comb begin
    grant_valid = eff0 | eff1;
    grant_id    = PORT_CPU;
`ifdef MEM_ARB_LOCK_EN
    if (lock && eff1) begin
      grant_id = PORT_DBG;
    end else
`endif
    if (eff0 && eff1) begin
      grant_id = ~last;
    end else if (eff1) begin
      grant_id = PORT_DBG;
    end else begin
      grant_id = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises accesses from the CPU (port 0) and the debug/program loader
//   (port 1) onto a single-port distributed RAM with asynchronous read.
//   Every access is: grant in IDLE or RESP, one ACCESS cycle driving the
//   memory from latched registers, one RESP cycle with a one-cycle ack.
//   Ports:
//     clk, rst                 clock (rising edge), async active-high reset
//     r0_* / r1_*              req/we/addr/wdata in, ack/rdata out per port
//     r1_lock                  (MEM_ARB_LOCK_EN only) port 1 priority hold
//     mem_a, mem_d, mem_we     memory address, write data, write enable
//     mem_spo                  asynchronous memory read data
//     busy                     FSM is not in IDLE
//     owner                    port of the current or most recent access
//   Optional feature macro: MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              r1_lock,
`endif

  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo,

  output logic              busy,
  output logic              owner
);

  logic [1:0]        state;
  logic              last;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_valid;
  logic              grant_id;
  logic [1:0]        req_mask;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // In RESP the owner's request is still up (it only sees its ack now), so
  // it is masked to keep the same port from being re-granted immediately.
  assign req_mask = (state == ST_RESP) ? port_onehot(owner) : 2'b00;

  rr_pick2 u_pick (
    .req0        (r0_req),
    .req1        (r1_req),
    .last        (last),
    .mask        (req_mask),
`ifdef MEM_ARB_LOCK_EN
    .lock        (r1_lock),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Inputs of the port being granted, ready to be latched.
  always_comb begin
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    sel_we    = r0_we;
    if (grant_id == PORT_DBG) begin
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
      sel_we    = r1_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last      <= PORT_DBG;
      owner     <= PORT_CPU;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_we    <= sel_we;
            owner     <= grant_id;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // For a write this captures the word before it is overwritten.
          rdata_q <= mem_spo;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          last <= owner;
          if (grant_valid) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_we    <= sel_we;
            owner     <= grant_id;
            state     <= ST_ACCESS;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pure decode of state: the async reset of state removes the write enable
  // immediately, so an aborted ACCESS never commits.
  assign mem_we = (state == ST_ACCESS) & lat_we;
  assign mem_a  = lat_addr;
  assign mem_d  = lat_wdata;
  assign busy   = (state != ST_IDLE);

  assign r0_ack   = (state == ST_RESP) & (owner == PORT_CPU);
  assign r1_ack   = (state == ST_RESP) & (owner == PORT_DBG);
  assign r0_rdata = r0_ack ? rdata_q : '0;
  assign r1_rdata = r1_ack ? rdata_q : '0;

endmodule
